i2c_reg_slave: RTL and testbench

I2C_REG_SLAVE -- requirements
Module: i2c_reg_slave

---
 rtl/i2c_reg_slave.sv | 241 ++++++++++++++++++++++++
 tb/tb_i2c_reg_slave.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_slave.sv
// I2C register slave: 8 x 8-bit registers behind a 7-bit bus address, with a pointer byte then data bytes.
// Optional macro I2C_REG_SLAVE_AUTOINC_EN advances the pointer after each data byte.
module i2c_reg_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [2:0] loc_addr,
  output logic [7:0] loc_rdata,
  output logic       wr_stb,
  output logic [2:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       error_slave
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK
  } state_t;

  state_t      state_r, state_n;
  logic [2:0]  scl_sync_r, sda_sync_r;
  logic [3:0]  cnt_r, cnt_n;
  logic [7:0]  shift_r, shift_n;
  logic        rw_r, rw_n, mack_r, mack_n;
  logic [2:0]  ptr_r, ptr_n, ptr_inc_s;
  logic [7:0]  regs_r [0:7];
  logic        sda_oe_r, sda_oe_n;
  logic        busy_r, busy_n, err_r, err_n, stb_r, stb_n;
  logic [2:0]  wr_addr_r;
  logic [7:0]  wr_data_r;
  logic        scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s, in_byte_s;

  // Index 1 is the synchronized level, index 2 the previous synchronized level.
  assign scl_s      = scl_sync_r[1];
  assign sda_s      = sda_sync_r[1];
  assign scl_rise_s = scl_s & ~scl_sync_r[2];
  assign scl_fall_s = ~scl_s & scl_sync_r[2];
  assign start_s    = scl_s & scl_sync_r[2] & sda_sync_r[2] & ~sda_s;
  assign stop_s     = scl_s & scl_sync_r[2] & ~sda_sync_r[2] & sda_s;
  assign in_byte_s  = ((state_r == ST_ADDR) || (state_r == ST_PTR) || (state_r == ST_WDATA) ||
                       (state_r == ST_RDATA)) && (cnt_r != 4'd0) && (cnt_r != 4'd8);

`ifdef I2C_REG_SLAVE_AUTOINC_EN
  assign ptr_inc_s = ptr_r + 3'd1;
`else
  assign ptr_inc_s = ptr_r;
`endif

  assign sda         = sda_oe_r ? 1'b0 : 1'bz;
  assign loc_rdata   = regs_r[loc_addr];
  assign wr_stb      = stb_r;
  assign wr_addr     = wr_addr_r;
  assign wr_data     = wr_data_r;
  assign busy        = busy_r;
  assign error_slave = err_r;

  // Bus line synchronizers plus one-clock history for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_r <= 3'b111;
      sda_sync_r <= 3'b111;
    end else begin
      scl_sync_r <= {scl_sync_r[1:0], scl};
      sda_sync_r <= {sda_sync_r[1:0], sda};
    end
  end

  // FSM next-state: bits sampled on scl rise, sda drive changed on scl fall.
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    shift_n  = shift_r;
    rw_n     = rw_r;
    mack_n   = mack_r;
    ptr_n    = ptr_r;
    sda_oe_n = sda_oe_r;
    busy_n   = busy_r;
    err_n    = 1'b0;
    stb_n    = 1'b0;
    if (start_s) begin
      state_n  = ST_ADDR;
      cnt_n    = 4'd0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
      err_n    = in_byte_s;
    end else if (stop_s) begin
      state_n  = ST_IDLE;
      cnt_n    = 4'd0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
      err_n    = in_byte_s;
    end else begin
      case (state_r)
        ST_IDLE: sda_oe_n = 1'b0;
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise_s && (cnt_r < 4'd8)) begin
            shift_n = {shift_r[6:0], sda_s};
            cnt_n   = cnt_r + 4'd1;
          end else if (scl_fall_s && (cnt_r == 4'd8)) begin
            cnt_n = 4'd0;
            case (state_r)
              ST_ADDR: begin
                if (shift_r[7:1] == SLAVE_ADDR) begin
                  state_n  = ST_ADDR_ACK;
                  sda_oe_n = 1'b1;
                  rw_n     = shift_r[0];
                  busy_n   = 1'b1;
                end else begin
                  state_n  = ST_IDLE;
                  sda_oe_n = 1'b0;
                end
              end
              ST_PTR: begin
                state_n  = ST_PTR_ACK;
                sda_oe_n = 1'b1;
                ptr_n    = shift_r[2:0];
              end
              default: begin
                state_n  = ST_WDATA_ACK;
                sda_oe_n = 1'b1;
              end
            endcase
          end else begin
            cnt_n = cnt_r;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall_s) begin
            cnt_n = 4'd0;
            if (rw_r) begin
              state_n  = ST_RDATA;
              shift_n  = regs_r[ptr_r];
              sda_oe_n = ~regs_r[ptr_r][7];
            end else begin
              state_n  = ST_PTR;
              sda_oe_n = 1'b0;
            end
          end else begin
            state_n = state_r;
          end
        end
        ST_PTR_ACK: begin
          if (scl_fall_s) begin
            state_n  = ST_WDATA;
            sda_oe_n = 1'b0;
          end else begin
            state_n = state_r;
          end
        end
        ST_WDATA_ACK: begin
          if (scl_rise_s) begin
            stb_n = 1'b1;
            ptr_n = ptr_inc_s;
          end else if (scl_fall_s) begin
            state_n  = ST_WDATA;
            sda_oe_n = 1'b0;
          end else begin
            state_n = state_r;
          end
        end
        ST_RDATA: begin
          if (scl_rise_s && (cnt_r < 4'd8)) begin
            cnt_n = cnt_r + 4'd1;
          end else if (scl_fall_s) begin
            if (cnt_r == 4'd8) begin
              state_n  = ST_RDATA_ACK;
              cnt_n    = 4'd0;
              sda_oe_n = 1'b0;
            end else begin
              shift_n  = {shift_r[6:0], 1'b0};
              sda_oe_n = ~shift_r[6];
            end
          end else begin
            cnt_n = cnt_r;
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise_s) begin
            mack_n = ~sda_s;
          end else if (scl_fall_s) begin
            if (mack_r) begin
              state_n  = ST_RDATA;
              ptr_n    = ptr_inc_s;
              shift_n  = regs_r[ptr_inc_s];
              sda_oe_n = ~regs_r[ptr_inc_s][7];
            end else begin
              state_n  = ST_IDLE;
              sda_oe_n = 1'b0;
            end
          end else begin
            mack_n = mack_r;
          end
        end
        default: begin
          state_n  = ST_IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

  // FSM state, register file and registered outputs; reset releases sda at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      shift_r   <= 8'h00;
      rw_r      <= 1'b0;
      mack_r    <= 1'b0;
      ptr_r     <= 3'd0;
      sda_oe_r  <= 1'b0;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
      stb_r     <= 1'b0;
      wr_addr_r <= 3'd0;
      wr_data_r <= 8'h00;
      for (int i = 0; i < 8; i++) regs_r[i] <= 8'h00;
    end else begin
      state_r  <= state_n;
      cnt_r    <= cnt_n;
      shift_r  <= shift_n;
      rw_r     <= rw_n;
      mack_r   <= mack_n;
      ptr_r    <= ptr_n;
      sda_oe_r <= sda_oe_n;
      busy_r   <= busy_n;
      err_r    <= err_n;
      stb_r    <= stb_n;
      if (stb_n) begin
        regs_r[ptr_r] <= shift_r;
        wr_addr_r     <= ptr_r;
        wr_data_r     <= shift_r;
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: bit-banged I2C master, vector table plus corner-case sequences.
module tb_i2c_reg_slave;

`ifdef I2C_REG_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda_lo;
  wire        sda;
  logic [2:0] loc_addr;
  logic [7:0] loc_rdata;
  logic       wr_stb;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       error_slave;

  pullup (sda);
  assign sda = sda_lo ? 1'b0 : 1'bz;

  i2c_reg_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .loc_addr(loc_addr), .loc_rdata(loc_rdata),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .error_slave(error_slave)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         stb_cnt = 0;
  int         err_cnt = 0;
  logic       stb_d = 1'b0;
  logic [2:0] last_addr = 3'd0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] vis_data = 8'h00;
  logic [7:0] exp_regs [0:7];
  logic [2:0] mptr;

  // Pulse monitor: counts strobes/errors and captures loc_rdata one clk after each strobe.
  always @(posedge clk) begin
    stb_d <= wr_stb;
    if (wr_stb) begin
      stb_cnt   <= stb_cnt + 1;
      last_addr <= wr_addr;
      last_data <= wr_data;
    end
    if (error_slave) err_cnt <= err_cnt + 1;
    if (stb_d) vis_data <= loc_rdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_lo = 1'b0; wq();
    scl = 1'b1;    wq();
    sda_lo = 1'b1; wq();
    scl = 1'b0;    wq();
  endtask

  task automatic i2c_stop();
    sda_lo = 1'b1; wq();
    scl = 1'b1;    wq();
    sda_lo = 1'b0; wq();
  endtask

  task automatic write_bit(input logic v);
    sda_lo = ~v; wq();
    scl = 1'b1;  wq(); wq();
    scl = 1'b0;  wq();
  endtask

  task automatic read_bit(output logic b);
    sda_lo = 1'b0; wq();
    scl = 1'b1;    wq();
    b = (sda === 1'b1);
    wq();
    scl = 1'b0;    wq();
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic x;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(x);
    ack = ~x;
  endtask

  task automatic rbyte(output logic [7:0] b, input logic mack);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      read_bit(x);
      b[i] = x;
    end
    write_bit(~mack);
  endtask

  task automatic model_write(input logic [7:0] d);
    exp_regs[mptr] = d;
    if (AUTOINC) mptr = mptr + 3'd1;
  endtask

  typedef struct {
    logic [2:0] ptr;
    logic [7:0] data;
    logic [2:0] exp_addr;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t       vecs [6];
  logic       ack;
  logic [7:0] rd;
  int         s0, e0;

  initial begin
    vecs[0] = '{3'd0, 8'h00, 3'd0, 8'h00};
    vecs[1] = '{3'd1, 8'hFF, 3'd1, 8'hFF};
    vecs[2] = '{3'd4, 8'hA5, 3'd4, 8'hA5};
    vecs[3] = '{3'd5, 8'h5A, 3'd5, 8'h5A};
    vecs[4] = '{3'd6, 8'h80, 3'd6, 8'h80};
    vecs[5] = '{3'd3, 8'h01, 3'd3, 8'h01};
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    mptr = 3'd0;

    rst = 1'b0; scl = 1'b1; sda_lo = 1'b0; loc_addr = 3'd0;
    repeat (5) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_stb", wr_stb, 1'b0);
    chk("rst_err", error_slave, 1'b0);
    chk("rst_waddr", wr_addr, 3'd0);
    chk("rst_wdata", wr_data, 8'h00);
    chk("rst_rdata", loc_rdata, 8'h00);
    chk("rst_sda", sda === 1'b1, 1'b1);
    rst = 1'b1;
    wq();

    // Single-byte write then bus read-back; pointer byte carries junk upper bits.
    for (int i = 0; i < 6; i++) begin
      loc_addr = vecs[i].ptr;
      s0 = stb_cnt;
      i2c_start();
      wbyte(8'hA0, ack);                  chk("v_addr_ack", ack, 1'b1);
      chk("v_busy", busy, 1'b1);
      wbyte({5'b11010, vecs[i].ptr}, ack); chk("v_ptr_ack", ack, 1'b1);
      mptr = vecs[i].ptr;
      wbyte(vecs[i].data, ack);           chk("v_data_ack", ack, 1'b1);
      model_write(vecs[i].data);
      i2c_stop();
      wq();
      chk("v_stb_cnt", stb_cnt - s0, 1);
      chk("v_wr_addr", last_addr, vecs[i].exp_addr);
      chk("v_wr_data", last_data, vecs[i].exp_rd);
      chk("v_visible", vis_data, vecs[i].exp_rd);
      chk("v_loc_rdata", loc_rdata, vecs[i].exp_rd);
      chk("v_busy_idle", busy, 1'b0);
      i2c_start();
      wbyte(8'hA0, ack);
      wbyte({5'b00000, vecs[i].ptr}, ack);
      i2c_start();
      wbyte(8'hA1, ack);                  chk("v_raddr_ack", ack, 1'b1);
      rbyte(rd, 1'b0);
      i2c_stop();
      chk("v_readback", rd, vecs[i].exp_rd);
    end

    // Write burst at pointer 2.
    s0 = stb_cnt;
    i2c_start();
    wbyte(8'hA0, ack); chk("wb_addr_ack", ack, 1'b1);
    wbyte(8'h02, ack); chk("wb_ptr_ack", ack, 1'b1);
    mptr = 3'd2;
    wbyte(8'h11, ack); chk("wb_d0_ack", ack, 1'b1); model_write(8'h11);
    wbyte(8'h22, ack); chk("wb_d1_ack", ack, 1'b1); model_write(8'h22);
    i2c_stop();
    wq();
    chk("wb_stb_cnt", stb_cnt - s0, 2);
    chk("wb_last_addr", last_addr, AUTOINC ? 3'd3 : 3'd2);
    loc_addr = 3'd2; #1 chk("wb_reg2", loc_rdata, exp_regs[2]);
    loc_addr = 3'd3; #1 chk("wb_reg3", loc_rdata, exp_regs[3]);

    // Read burst from pointer 2 via repeated START, ACK then NACK.
    i2c_start();
    wbyte(8'hA0, ack);
    wbyte(8'h02, ack);
    mptr = 3'd2;
    i2c_start();
    wbyte(8'hA1, ack); chk("rb_addr_ack", ack, 1'b1);
    rbyte(rd, 1'b1);   chk("rb_byte0", rd, exp_regs[mptr]);
    if (AUTOINC) mptr = mptr + 3'd1;
    rbyte(rd, 1'b0);   chk("rb_byte1", rd, exp_regs[mptr]);
    chk("rb_sda_released", sda === 1'b1, 1'b1);
    i2c_stop();

    // Address mismatch.
    s0 = stb_cnt;
    i2c_start();
    wbyte(8'hA2, ack); chk("mm_nack", ack, 1'b0);
    chk("mm_busy", busy, 1'b0);
    wbyte(8'h33, ack); chk("mm_data_nack", ack, 1'b0);
    i2c_stop();
    chk("mm_no_stb", stb_cnt - s0, 0);

    // Pointer wrap from 7.
    i2c_start();
    wbyte(8'hA0, ack);
    wbyte(8'h07, ack);
    mptr = 3'd7;
    wbyte(8'hAA, ack); chk("wr_d0_ack", ack, 1'b1); model_write(8'hAA);
    wbyte(8'hBB, ack); chk("wr_d1_ack", ack, 1'b1); model_write(8'hBB);
    i2c_stop();
    wq();
    chk("wr_last_addr", last_addr, AUTOINC ? 3'd0 : 3'd7);
    loc_addr = 3'd7; #1 chk("wr_reg7", loc_rdata, exp_regs[7]);
    loc_addr = 3'd0; #1 chk("wr_reg0", loc_rdata, exp_regs[0]);

    // STOP after four data bits: one error pulse, nothing written.
    s0 = stb_cnt; e0 = err_cnt;
    i2c_start();
    wbyte(8'hA0, ack);
    wbyte(8'h05, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_stop();
    wq();
    chk("er_err_cnt", err_cnt - e0, 1);
    chk("er_no_stb", stb_cnt - s0, 0);
    loc_addr = 3'd5; #1 chk("er_reg5", loc_rdata, exp_regs[5]);
    chk("er_busy", busy, 1'b0);

    // Reset while the slave drives its read-address ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(rd_addr_bit(i));
    sda_lo = 1'b0; wq();
    scl = 1'b1;    wq();
    chk("rs_ack_driven", sda === 1'b0, 1'b1);
    chk("rs_busy_pre", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("rs_sda_async", sda === 1'b1, 1'b1);
    @(negedge clk);
    chk("rs_busy", busy, 1'b0);
    chk("rs_stb", wr_stb, 1'b0);
    chk("rs_err", error_slave, 1'b0);
    chk("rs_waddr", wr_addr, 3'd0);
    chk("rs_wdata", wr_data, 8'h00);
    loc_addr = 3'd7; #1 chk("rs_reg7", loc_rdata, 8'h00);
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    scl = 1'b0; wq();
    rst = 1'b1; wq();
    i2c_stop();

    // Fresh transaction after reset.
    i2c_start();
    wbyte(8'hA0, ack); chk("fr_addr_ack", ack, 1'b1);
    wbyte(8'h01, ack);
    wbyte(8'h3C, ack); chk("fr_data_ack", ack, 1'b1);
    i2c_stop();
    loc_addr = 3'd1; #1 chk("fr_reg1", loc_rdata, 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  function automatic logic rd_addr_bit(input int i);
    logic [7:0] a;
    a = 8'hA1;
    return a[i];
  endfunction

endmodule
